// File: rtl/dcmi_rx_checker_if.sv
// rtl/dcmi_rx_checker_if.sv - DCMI sink bus: sampled inputs, per-frame results, counters
interface dcmi_rx_checker_if #(
  parameter int LEN_BITS = 10,
  parameter int CNT_BITS = 16
);
  logic [7:0]          data;
  logic                dsync;
  logic                clken;
  logic                check_en;
  logic [LEN_BITS:0]   exp_len;
  logic                busy;
  logic                frame_done;
  logic [LEN_BITS:0]   frame_len;
  logic [7:0]          frame_sum;
  logic                frame_ok;
  logic [LEN_BITS:0]   err_idx;
  logic [CNT_BITS-1:0] frame_cnt;
  logic [CNT_BITS-1:0] err_cnt;

  modport master (
    output data, dsync, clken, check_en, exp_len,
    input  busy, frame_done, frame_len, frame_sum, frame_ok, err_idx, frame_cnt, err_cnt
  );

  modport slave (
    input  data, dsync, clken, check_en, exp_len,
    output busy, frame_done, frame_len, frame_sum, frame_ok, err_idx, frame_cnt, err_cnt
  );
endinterface

// File: rtl/dcmi_rx_checker.sv
// rtl/dcmi_rx_checker.sv - DCMI frame sink: length, checksum, pattern check, counters
module dcmi_rx_checker #(
  parameter int LEN_BITS = 10,
  parameter int CNT_BITS = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcmi_rx_checker_if.slave   bus
);

  localparam int LW = LEN_BITS + 1;
  // Saturation value one above the largest legal frame marks overflow.
  localparam logic [LEN_BITS:0] LEN_MAX  = LW'(2**LEN_BITS + 1);
  localparam logic [LEN_BITS:0] ERR_NONE = '1;

  typedef enum logic [1:0] {
    S_WAIT_LOW,
    S_IDLE,
    S_RECV,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_BITS:0]   len_q, len_d;
  logic [7:0]          sum_q, sum_d;
  logic                mism_q, mism_d;
  logic [LEN_BITS:0]   idx_q, idx_d;
  logic                chk_q, chk_d;
  logic [LEN_BITS:0]   exp_q, exp_d;
  logic [LEN_BITS:0]   out_len_q, out_len_d;
  logic [7:0]          out_sum_q, out_sum_d;
  logic                out_ok_q, out_ok_d;
  logic [LEN_BITS:0]   out_idx_q, out_idx_d;
  logic [CNT_BITS-1:0] fcnt_q, fcnt_d;
  logic [CNT_BITS-1:0] ecnt_q, ecnt_d;
  logic                ok_c;
  logic                first_bad_c;

  // State and datapath registers; reset re-arms in WAIT_LOW so a partial frame is never counted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_WAIT_LOW;
      len_q     <= '0;
      sum_q     <= '0;
      mism_q    <= 1'b0;
      idx_q     <= ERR_NONE;
      chk_q     <= 1'b0;
      exp_q     <= '0;
      out_len_q <= '0;
      out_sum_q <= '0;
      out_ok_q  <= 1'b0;
      out_idx_q <= ERR_NONE;
      fcnt_q    <= '0;
      ecnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      mism_q    <= mism_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      exp_q     <= exp_d;
      out_len_q <= out_len_d;
      out_sum_q <= out_sum_d;
      out_ok_q  <= out_ok_d;
      out_idx_q <= out_idx_d;
      fcnt_q    <= fcnt_d;
      ecnt_q    <= ecnt_d;
    end
  end

  // Next-state and per-sample accumulation; results and counters load on entry to DONE.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    mism_d      = mism_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    exp_d       = exp_q;
    out_len_d   = out_len_q;
    out_sum_d   = out_sum_q;
    out_ok_d    = out_ok_q;
    out_idx_d   = out_idx_q;
    fcnt_d      = fcnt_q;
    ecnt_d      = ecnt_q;
    ok_c        = (len_q != LEN_MAX) && (!chk_q || !mism_q) &&
                  ((exp_q == '0) || (len_q == exp_q));
    first_bad_c = 1'b0;

    case (state_q)
      S_WAIT_LOW: begin
        if (bus.clken && !bus.dsync) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.clken && bus.dsync) begin
          state_d     = S_RECV;
          len_d       = LW'(1);
          sum_d       = bus.data;
          chk_d       = bus.check_en;
          exp_d       = bus.exp_len;
          first_bad_c = bus.check_en && (bus.data != 8'h00);
          mism_d      = first_bad_c;
          idx_d       = first_bad_c ? '0 : ERR_NONE;
        end
      end
      S_RECV: begin
        if (bus.clken) begin
          if (bus.dsync) begin
            if (len_q != LEN_MAX) len_d = len_q + LW'(1);
            sum_d = sum_q + bus.data;
            if (chk_q && !mism_q && (bus.data != 8'(len_q))) begin
              mism_d = 1'b1;
              idx_d  = len_q;
            end
          end else begin
            state_d   = S_DONE;
            out_len_d = len_q;
            out_sum_d = sum_q;
            out_ok_d  = ok_c;
            out_idx_d = idx_q;
            if (fcnt_q != '1) fcnt_d = fcnt_q + CNT_BITS'(1);
            if (!ok_c && (ecnt_q != '1)) ecnt_d = ecnt_q + CNT_BITS'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_WAIT_LOW;
      end
    endcase
  end

  assign bus.busy       = (state_q == S_RECV);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.frame_len  = out_len_q;
  assign bus.frame_sum  = out_sum_q;
  assign bus.frame_ok   = out_ok_q;
  assign bus.err_idx    = out_idx_q;
  assign bus.frame_cnt  = fcnt_q;
  assign bus.err_cnt    = ecnt_q;

endmodule
